// File: rtl/vram_fetch_arbiter.sv
// rtl/vram_fetch_arbiter.sv - text VRAM arbiter between display cell prefetch and host port
module vram_fetch_arbiter #(
   parameter int H_ACTIVE = 640,
   parameter int H_TOTAL  = 800,
   parameter int V_ACTIVE = 480,
   parameter int V_TOTAL  = 525,
   parameter int COLS     = 80,
   parameter int ROWS     = 30,
   parameter int ADDR_W   = 12,
   parameter int DATA_W   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [11:0]       pixel_x,
   input  logic [11:0]       pixel_y,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic              host_ack,
   output logic              host_rvalid,
   output logic [DATA_W-1:0] host_rdata,
   output logic              disp_valid,
   output logic [DATA_W-1:0] disp_data,
   output logic [6:0]        disp_col,
   output logic              vram_en,
   output logic              vram_we,
   output logic [ADDR_W-1:0] vram_addr,
   output logic [DATA_W-1:0] vram_wdata,
   input  logic [DATA_W-1:0] vram_rdata
);

   // Owner of a read in flight; host writes never return data.
   typedef enum logic [1:0] {
      TAG_NONE = 2'd0,
      TAG_DISP = 2'd1,
      TAG_HOST = 2'd2
   } tag_e;

   logic              vram_en_q, vram_en_d;
   logic              vram_we_q, vram_we_d;
   logic [ADDR_W-1:0] vram_addr_q, vram_addr_d;
   logic [DATA_W-1:0] vram_wdata_q, vram_wdata_d;
   logic              host_ack_q, host_ack_d;
   tag_e              tag0_q, tag0_d, tag1_q, tag1_d;
   logic [6:0]        col0_q, col0_d, col1_q, col1_d;
   logic              disp_valid_q, disp_valid_d;
   logic [DATA_W-1:0] disp_data_q, disp_data_d;
   logic [6:0]        disp_col_q, disp_col_d;
   logic              host_rvalid_q, host_rvalid_d;
   logic [DATA_W-1:0] host_rdata_q, host_rdata_d;

   logic [11:0]       next_line;
   logic              col_trig;
   logic              line_trig;
   logic              disp_trig;
   logic              host_grant;
   logic [7:0]        tgt_row;
   logic [6:0]        tgt_col;
   logic [ADDR_W-1:0] disp_addr;

   // Trigger decode, arbitration and next-state for the whole fetch pipeline.
   always_comb begin
      next_line  = (pixel_y == 12'(V_TOTAL - 1)) ? 12'd0 : pixel_y + 12'd1;
      // Column prefetch runs one cell ahead inside a visible line.
      col_trig   = (pixel_x[2:0] == 3'd0) && (pixel_x < 12'(H_ACTIVE - 8)) &&
                   ((pixel_y >> 4) < 12'(ROWS));
      // Line prefetch in the last cell slot of the line fetches column 0 of the next line.
      line_trig  = (pixel_x == 12'(H_TOTAL - 8)) && (next_line < 12'(V_ACTIVE));
      disp_trig  = col_trig || line_trig;
      // A host request is never granted in its own ack cycle.
      host_grant = host_req && !host_ack_q && !disp_trig;

      tgt_row    = 8'd0;
      tgt_col    = 7'd0;
      if (line_trig) begin
         tgt_row = next_line[11:4];
         tgt_col = 7'd0;
      end else if (col_trig) begin
         tgt_row = pixel_y[11:4];
         tgt_col = pixel_x[9:3] + 7'd1;
      end
      disp_addr  = ADDR_W'(tgt_row) * ADDR_W'(COLS) + ADDR_W'(tgt_col);

      vram_en_d    = disp_trig || host_grant;
      vram_we_d    = host_grant && host_we;
      vram_addr_d  = vram_addr_q;
      vram_wdata_d = vram_wdata_q;
      host_ack_d   = host_grant;
      tag0_d       = TAG_NONE;
      col0_d       = col0_q;
      if (disp_trig) begin
         vram_addr_d = disp_addr;
         tag0_d      = TAG_DISP;
         col0_d      = tgt_col;
      end else if (host_grant) begin
         vram_addr_d  = host_addr;
         vram_wdata_d = host_wdata;
         tag0_d       = host_we ? TAG_NONE : TAG_HOST;
      end

      tag1_d = tag0_q;
      col1_d = col0_q;

      // Read data is on vram_rdata while the tag sits in the second stage.
      disp_valid_d  = (tag1_q == TAG_DISP);
      disp_data_d   = disp_valid_d ? vram_rdata : disp_data_q;
      disp_col_d    = disp_valid_d ? col1_q : disp_col_q;
      host_rvalid_d = (tag1_q == TAG_HOST);
      host_rdata_d  = host_rvalid_d ? vram_rdata : host_rdata_q;
   end

   // Pipeline registers; reset drops any reads still in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vram_en_q     <= 1'b0;
         vram_we_q     <= 1'b0;
         vram_addr_q   <= '0;
         vram_wdata_q  <= '0;
         host_ack_q    <= 1'b0;
         tag0_q        <= TAG_NONE;
         tag1_q        <= TAG_NONE;
         col0_q        <= 7'd0;
         col1_q        <= 7'd0;
         disp_valid_q  <= 1'b0;
         disp_data_q   <= '0;
         disp_col_q    <= 7'd0;
         host_rvalid_q <= 1'b0;
         host_rdata_q  <= '0;
      end else begin
         vram_en_q     <= vram_en_d;
         vram_we_q     <= vram_we_d;
         vram_addr_q   <= vram_addr_d;
         vram_wdata_q  <= vram_wdata_d;
         host_ack_q    <= host_ack_d;
         tag0_q        <= tag0_d;
         tag1_q        <= tag1_d;
         col0_q        <= col0_d;
         col1_q        <= col1_d;
         disp_valid_q  <= disp_valid_d;
         disp_data_q   <= disp_data_d;
         disp_col_q    <= disp_col_d;
         host_rvalid_q <= host_rvalid_d;
         host_rdata_q  <= host_rdata_d;
      end
   end

   assign vram_en     = vram_en_q;
   assign vram_we     = vram_we_q;
   assign vram_addr   = vram_addr_q;
   assign vram_wdata  = vram_wdata_q;
   assign host_ack    = host_ack_q;
   assign disp_valid  = disp_valid_q;
   assign disp_data   = disp_data_q;
   assign disp_col    = disp_col_q;
   assign host_rvalid = host_rvalid_q;
   assign host_rdata  = host_rdata_q;

endmodule

// File: tb/tb_vram_fetch_arbiter.sv
// tb/tb_vram_fetch_arbiter.sv - scoreboard bench for vram_fetch_arbiter
module tb_vram_fetch_arbiter;
   localparam int H_ACTIVE = 640;
   localparam int H_TOTAL  = 800;
   localparam int V_ACTIVE = 480;
   localparam int V_TOTAL  = 525;
   localparam int COLS     = 80;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [11:0] pixel_x, pixel_y;
   logic        host_req, host_we;
   logic [11:0] host_addr;
   logic [15:0] host_wdata;
   logic        host_ack, host_rvalid, disp_valid;
   logic [15:0] host_rdata, disp_data;
   logic [6:0]  disp_col;
   logic        vram_en, vram_we;
   logic [11:0] vram_addr;
   logic [15:0] vram_wdata;
   logic [15:0] vram_rdata = 16'd0;

   vram_fetch_arbiter dut (
      .clk(clk), .rst_n(rst_n), .pixel_x(pixel_x), .pixel_y(pixel_y),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_ack(host_ack), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
      .disp_valid(disp_valid), .disp_data(disp_data), .disp_col(disp_col),
      .vram_en(vram_en), .vram_we(vram_we), .vram_addr(vram_addr), .vram_wdata(vram_wdata),
      .vram_rdata(vram_rdata)
   );

   always #5 clk = ~clk;

   typedef struct { int due; bit we; bit host; logic [11:0] addr; logic [15:0] wdata; } acc_t;
   typedef struct { int due; bit disp; logic [6:0] col; logic [15:0] data; } rsp_t;

   acc_t        acc_q[$];
   rsp_t        rsp_q[$];
   logic [15:0] mem     [4096];
   logic [15:0] ref_mem [4096];
   int          cyc = 0;
   int          errors = 0;
   int          checks = 0;
   bit          rand_host = 0;
   bit          hold_once = 0;

   task automatic check(string name, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Single-port VRAM with one cycle read latency
   always @(posedge clk) begin
      if (vram_en) begin
         if (vram_we) mem[vram_addr] <= vram_wdata;
         else         vram_rdata <= mem[vram_addr];
      end
   end

   // Reference model: decides each cycle who owns the VRAM and what must come back
   bit m_ack = 0;
   int m_px, m_py, m_line, m_col, m_addr;
   bit m_trig;
   always @(negedge clk) begin
      if (!rst_n) begin
         m_ack = 0;
      end else begin
         m_px = int'(pixel_x);
         m_py = int'(pixel_y);
         m_trig = 0;
         m_line = 0;
         m_col = 0;
         if (m_px % 8 == 0 && m_px / 8 <= COLS - 2 && m_py < V_ACTIVE) begin
            m_trig = 1;
            m_line = m_py;
            m_col  = m_px / 8 + 1;
         end else if (m_px == H_TOTAL - 8) begin
            m_line = (m_py == V_TOTAL - 1) ? 0 : m_py + 1;
            m_col  = 0;
            m_trig = (m_line < V_ACTIVE);
         end
         if (m_trig) begin
            m_addr = ((m_line / 16) * COLS + m_col) % 4096;
            acc_q.push_back('{due: cyc + 1, we: 0, host: 0, addr: 12'(m_addr), wdata: 16'd0});
            rsp_q.push_back('{due: cyc + 3, disp: 1, col: 7'(m_col), data: ref_mem[m_addr]});
            m_ack = 0;
         end else if (host_req && !m_ack) begin
            acc_q.push_back('{due: cyc + 1, we: host_we, host: 1, addr: host_addr, wdata: host_wdata});
            if (host_we) ref_mem[host_addr] = host_wdata;
            else rsp_q.push_back('{due: cyc + 3, disp: 0, col: 7'd0, data: ref_mem[host_addr]});
            m_ack = 1;
         end else begin
            m_ack = 0;
         end
      end
   end

   // Monitor: compares DUT outputs with whatever the scoreboard holds for this cycle
   acc_t        a;
   rsp_t        r;
   bit          exp_en, exp_rsp;
   logic [15:0] last_disp_data = 16'd0;
   logic [6:0]  last_disp_col  = 7'd0;
   logic [15:0] last_host_rdata = 16'd0;
   always @(negedge clk) begin
      if (!rst_n) begin
         check("reset_outputs",
               {22'd0, vram_en, vram_we, host_ack, host_rvalid, disp_valid,
                (vram_addr != 0), (vram_wdata != 0), (host_rdata != 0),
                (disp_data != 0), (disp_col != 0)}, 32'd0);
         acc_q.delete();
         rsp_q.delete();
         last_disp_data  = 16'd0;
         last_disp_col   = 7'd0;
         last_host_rdata = 16'd0;
      end else begin
         exp_en = 0;
         a = '{due: 0, we: 0, host: 0, addr: 12'd0, wdata: 16'd0};
         if (acc_q.size() > 0 && acc_q[0].due == cyc) begin
            a = acc_q.pop_front();
            exp_en = 1;
         end
         check("vram_en", vram_en, exp_en);
         check("vram_we", vram_we, exp_en & a.we);
         check("host_ack", host_ack, exp_en & a.host);
         if (exp_en) check("vram_addr", vram_addr, a.addr);
         if (exp_en && a.we) check("vram_wdata", vram_wdata, a.wdata);

         exp_rsp = 0;
         r = '{due: 0, disp: 0, col: 7'd0, data: 16'd0};
         if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
            r = rsp_q.pop_front();
            exp_rsp = 1;
         end
         if (exp_rsp && r.disp) begin
            last_disp_data = r.data;
            last_disp_col  = r.col;
         end
         if (exp_rsp && !r.disp) last_host_rdata = r.data;
         check("disp_valid", disp_valid, exp_rsp & r.disp);
         check("host_rvalid", host_rvalid, exp_rsp & !r.disp);
         check("disp_data", disp_data, last_disp_data);
         check("disp_col", disp_col, last_disp_col);
         check("host_rdata", host_rdata, last_host_rdata);
      end
   end

   task automatic run(int y, int x0, int n);
      for (int i = 0; i < n; i++) begin
         int x  = x0 + i;
         int yy = y;
         if (x >= H_TOTAL) begin
            x  = x - H_TOTAL;
            yy = (yy + 1) % V_TOTAL;
         end
         pixel_x = 12'(x);
         pixel_y = 12'(yy);
         if (host_req && host_ack) begin
            if (hold_once) hold_once = 0;
            else host_req = 0;
         end
         if (rand_host && !host_req && $urandom_range(0, 2) == 0) begin
            host_req   = 1'b1;
            host_we    = 1'($urandom_range(0, 1));
            host_addr  = ($urandom_range(0, 1) == 1) ? 12'($urandom_range(0, 2399)) : 12'($urandom);
            host_wdata = 16'($urandom);
         end
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) begin
         mem[i]     = 16'($urandom);
         ref_mem[i] = mem[i];
      end
      rst_n = 0;
      pixel_x = 0; pixel_y = 0;
      host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1;
      run(0, 0, 40);
      run(15, 780, 30);
      run(524, 780, 30);
      run(479, 600, 220);
      run(500, 780, 30);

      // Host read with no display slot nearby; request held through its ack cycle
      host_req = 1; host_we = 0; host_addr = 12'h123; hold_once = 1;
      run(100, 700, 8);

      // Host write colliding with a display fetch of the same word
      host_req = 1; host_we = 1; host_addr = 12'd3; host_wdata = 16'hBEEF;
      run(5, 16, 6);
      run(5, 16, 6);

      // Reset while a host read is in flight
      host_req = 1; host_we = 0; host_addr = 12'h200;
      run(100, 700, 2);
      rst_n = 0;
      run(100, 702, 3);
      rst_n = 1;
      run(100, 705, 8);

      rand_host = 1;
      repeat (40) run($urandom_range(0, V_TOTAL - 1), $urandom_range(0, H_TOTAL - 1), $urandom_range(20, 80));
      rand_host = 0;
      hold_once = 0;
      for (int k = 0; k < 10 && host_req; k++) run(490, 100, 1);
      run(490, 200, 8);

      checks++;
      if (acc_q.size() != 0 || rsp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", acc_q.size() + rsp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
